video_dram_port: RTL and testbench

- Video-side port of the DRAM arbiter; the serving end of the `video_go` / `video_strobe` / `video_data` interface consumed by the video fetcher.
- While `video_go` is high it claims DRAM cycles at 1/8 or 1/4 bandwidth, generates sequential word addresses from a frame base, and returns read words as single-clock `video_strobe` pulses.
- Non-video DRAM cycles are flagged free for CPU use.

---
 rtl/video_dram_port_pkg.sv | 13 +
 rtl/video_addr_ctr.sv | 20 ++
 rtl/video_dram_port.sv | 73 +++++++
 tb/tb_video_dram_port.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/video_dram_port_pkg.sv
// video_dram_port_pkg: shared constants for the video DRAM port
// Holds the default DRAM word-address width, the bandwidth-select encodings
// and the slot-counter masks used to pick video-owned DRAM cycles.
package video_dram_port_pkg;
   localparam int DRAM_AW = 21;
   localparam logic BW_EIGHTH = 1'b0;
   localparam logic BW_QUARTER = 1'b1;
   localparam logic [2:0] SLOT_MASK_8 = 3'b111;
   localparam logic [2:0] SLOT_MASK_4 = 3'b011;
   function automatic logic [2:0] slot_mask(input logic bw);
      return (bw == BW_QUARTER) ? SLOT_MASK_4 : SLOT_MASK_8;
   endfunction
endpackage

// File: rtl/video_addr_ctr.sv
// video_addr_ctr: frame word-address counter with load and modulo-2^AW increment
// Ports: clk, rst (sync, active-high), load/base (frame reload, wins over inc),
// inc (advance one word), addr (current word address).
module video_addr_ctr
   import video_dram_port_pkg::*;
#(
   parameter int AW = DRAM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          inc,
   input  logic [AW-1:0] base,
   output logic [AW-1:0] addr
);
   always_ff @(posedge clk)
      if (rst) addr <= '0;
      else if (load) addr <= base;
      else if (inc) addr <= addr + AW'(1);
endmodule

// File: rtl/video_dram_port.sv
// video_dram_port: video-side DRAM arbiter port issuing sequential reads at 1/8 or 1/4 bandwidth
// Ports: clk, rst (sync, active-high); cend/pre_cend DRAM cycle strobes;
// video_go, frame_start, video_base, bw_quarter from the fetcher side;
// dram_video_cycle, cpu_slot_free, dram_addr ownership/address outputs;
// dram_rdata/dram_rvalid read return; video_data/video_strobe to fetcher;
// overrun_err sticky flag for a read issued while the previous one is outstanding.
module video_dram_port
   import video_dram_port_pkg::*;
#(
   parameter int AW = DRAM_AW,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cend,
   input  logic          pre_cend,
   input  logic          video_go,
   input  logic          frame_start,
   input  logic [AW-1:0] video_base,
   input  logic          bw_quarter,
   output logic          dram_video_cycle,
   output logic          cpu_slot_free,
   output logic [AW-1:0] dram_addr,
   input  logic [DW-1:0] dram_rdata,
   input  logic          dram_rvalid,
   output logic [DW-1:0] video_data,
   output logic          video_strobe,
   output logic          overrun_err
);
   logic [2:0]    slot_ctr;
   logic          own_next;
   logic          pending;
   logic          issue;
   logic          deliver;
   logic [AW-1:0] vaddr;
   assign issue = cend & own_next;
   assign deliver = dram_rvalid & pending;
   assign cpu_slot_free = ~dram_video_cycle;
   video_addr_ctr #(.AW(AW)) u_addr_ctr (
      .clk  (clk),
      .rst  (rst),
      .load (frame_start),
      .inc  (issue),
      .base (video_base),
      .addr (vaddr)
   );
   always_ff @(posedge clk)
      if (rst) begin
         slot_ctr         <= '0;
         own_next         <= 1'b0;
         pending          <= 1'b0;
         dram_video_cycle <= 1'b0;
         dram_addr        <= '0;
         video_data       <= '0;
         video_strobe     <= 1'b0;
         overrun_err      <= 1'b0;
      end else begin
         if (cend) begin
            slot_ctr         <= video_go ? slot_ctr + 3'd1 : 3'd0;
            dram_video_cycle <= own_next;
         end
         // slot_ctr is 0 whenever video_go was low, so the first decision in a window claims the cycle
         if (pre_cend) own_next <= video_go & ((slot_ctr & slot_mask(bw_quarter)) == 3'd0);
         // a new issue keeps pending set even if the previous word returns on the same clk
         if (issue) begin
            dram_addr <= vaddr;
            pending   <= 1'b1;
            if (pending & ~dram_rvalid) overrun_err <= 1'b1;
         end else if (dram_rvalid) pending <= 1'b0;
         video_strobe <= deliver;
         if (deliver) video_data <= dram_rdata;
      end
endmodule

// File: tb/tb_video_dram_port.sv
// tb_video_dram_port: directed self-checking bench for video_dram_port
module tb_video_dram_port;
   logic        clk;
   logic        rst;
   logic        cend;
   logic        pre_cend;
   logic        video_go;
   logic        frame_start;
   logic [20:0] video_base;
   logic        bw_quarter;
   logic        dram_video_cycle;
   logic        cpu_slot_free;
   logic [20:0] dram_addr;
   logic [15:0] dram_rdata;
   logic        dram_rvalid;
   logic [15:0] video_data;
   logic        video_strobe;
   logic        overrun_err;
   int          checks = 0;
   int          errors = 0;
   logic [20:0] last_addr;
   logic [15:0] last_data;

   video_dram_port dut (
      .clk              (clk),
      .rst              (rst),
      .cend             (cend),
      .pre_cend         (pre_cend),
      .video_go         (video_go),
      .frame_start      (frame_start),
      .video_base       (video_base),
      .bw_quarter       (bw_quarter),
      .dram_video_cycle (dram_video_cycle),
      .cpu_slot_free    (cpu_slot_free),
      .dram_addr        (dram_addr),
      .dram_rdata       (dram_rdata),
      .dram_rvalid      (dram_rvalid),
      .video_data       (video_data),
      .video_strobe     (video_strobe),
      .overrun_err      (overrun_err)
   );

   initial clk = 1'b0;
   always #18 clk = ~clk;

   task automatic pulse_frame(input logic [20:0] base);
      @(negedge clk);
      frame_start = 1'b1;
      video_base = base;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   // One 3-clk DRAM cycle: pre_cend (with optional read return), then cend, then idle.
   // stb/dat are sampled one clk after the return; own/addr one clk after cend.
   task automatic dram_cycle(input logic go, input logic q, input logic rv, input logic [15:0] rd,
                             output logic own, output logic [20:0] addr,
                             output logic stb, output logic [15:0] dat);
      @(negedge clk);
      video_go = go;
      bw_quarter = q;
      pre_cend = 1'b1;
      dram_rvalid = rv;
      dram_rdata = rd;
      @(negedge clk);
      stb = video_strobe;
      dat = video_data;
      pre_cend = 1'b0;
      dram_rvalid = 1'b0;
      cend = 1'b1;
      @(negedge clk);
      cend = 1'b0;
      own = dram_video_cycle;
      addr = dram_addr;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++; if (dram_video_cycle !== 1'b0) begin errors++; $display("FAIL reset_own got %0b want 0", dram_video_cycle); end
      checks++; if (cpu_slot_free !== 1'b1) begin errors++; $display("FAIL reset_cpu_free got %0b want 1", cpu_slot_free); end
      checks++; if (dram_addr !== 21'h0) begin errors++; $display("FAIL reset_addr got %h want 0", dram_addr); end
      checks++; if (video_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %0b want 0", video_strobe); end
      checks++; if (video_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0", video_data); end
      checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun_err); end
      last_addr = 21'h0;
      last_data = 16'h0;
   endtask

   // n cycles with video_go high followed by one closing cycle with video_go low;
   // each video-owned read is returned in the following DRAM cycle.
   task automatic test_window(input logic q, input logic [20:0] base, input int n);
      logic        own, stb, prev, exp_own;
      logic [20:0] a, ea;
      logic [15:0] d, rd;
      int          nown, nstb;
      pulse_frame(base);
      ea = base;
      prev = 1'b0;
      nown = 0;
      nstb = 0;
      for (int k = 0; k <= n; k++) begin
         rd = 16'hA000 + 16'(k);
         dram_cycle(k < n, q, prev, rd, own, a, stb, d);
         exp_own = (k < n) && (q ? (k % 4 == 0) : (k % 8 == 0));
         if (exp_own) begin
            last_addr = ea;
            ea = ea + 21'd1;
         end
         checks++; if (own !== exp_own) begin errors++; $display("FAIL win_own q=%0b k=%0d got %0b want %0b", q, k, own, exp_own); end
         checks++; if (cpu_slot_free !== ~exp_own) begin errors++; $display("FAIL win_cpu_free q=%0b k=%0d got %0b want %0b", q, k, cpu_slot_free, ~exp_own); end
         checks++; if (a !== last_addr) begin errors++; $display("FAIL win_addr q=%0b k=%0d got %h want %h", q, k, a, last_addr); end
         checks++; if (stb !== prev) begin errors++; $display("FAIL win_strobe q=%0b k=%0d got %0b want %0b", q, k, stb, prev); end
         if (prev) begin
            last_data = rd;
            checks++; if (d !== rd) begin errors++; $display("FAIL win_data q=%0b k=%0d got %h want %h", q, k, d, rd); end
         end
         nown += int'(own);
         nstb += int'(stb);
         prev = exp_own;
      end
      checks++; if (nown != (q ? (n + 3) / 4 : (n + 7) / 8)) begin errors++; $display("FAIL win_count q=%0b got %0d want %0d", q, nown, q ? (n + 3) / 4 : (n + 7) / 8); end
      checks++; if (nstb != nown) begin errors++; $display("FAIL win_strobes q=%0b got %0d want %0d", q, nstb, nown); end
      checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL win_overrun got %0b want 0", overrun_err); end
   endtask

   task automatic test_cpu_rvalid();
      logic        own, stb;
      logic [20:0] a;
      logic [15:0] d;
      dram_cycle(1'b0, 1'b0, 1'b1, 16'hBEEF, own, a, stb, d);
      checks++; if (stb !== 1'b0) begin errors++; $display("FAIL cpu_strobe got %0b want 0", stb); end
      checks++; if (d !== last_data) begin errors++; $display("FAIL cpu_data got %h want %h", d, last_data); end
      checks++; if (own !== 1'b0) begin errors++; $display("FAIL cpu_own got %0b want 0", own); end
      checks++; if (a !== last_addr) begin errors++; $display("FAIL cpu_addr_hold got %h want %h", a, last_addr); end
   endtask

   task automatic test_overrun();
      logic        own, stb;
      logic [20:0] a;
      logic [15:0] d;
      pulse_frame(21'h00300);
      for (int k = 0; k <= 6; k++) begin
         dram_cycle(k < 6, 1'b1, k == 5, 16'hC0DE, own, a, stb, d);
         checks++; if (overrun_err !== (k >= 4)) begin errors++; $display("FAIL ovr_flag k=%0d got %0b want %0b", k, overrun_err, k >= 4); end
         if (k == 4) begin
            checks++; if (a !== 21'h00301) begin errors++; $display("FAIL ovr_addr got %h want 00301", a); end
         end
         if (k == 5) begin
            checks++; if (stb !== 1'b1 || d !== 16'hC0DE) begin errors++; $display("FAIL ovr_late_data got %0b/%h want 1/c0de", stb, d); end
         end
      end
      repeat (3) @(negedge clk);
      checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b want 1", overrun_err); end
   endtask

   task automatic test_reset_mid();
      logic        own, stb;
      logic [20:0] a;
      logic [15:0] d;
      pulse_frame(21'h00ABC);
      dram_cycle(1'b1, 1'b1, 1'b0, 16'h0, own, a, stb, d);
      checks++; if (own !== 1'b1 || a !== 21'h00ABC) begin errors++; $display("FAIL rmid_issue got %0b/%h want 1/00abc", own, a); end
      rst = 1'b1;
      video_go = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      dram_rvalid = 1'b1;
      dram_rdata = 16'h5A5A;
      @(negedge clk);
      dram_rvalid = 1'b0;
      checks++; if (video_strobe !== 1'b0) begin errors++; $display("FAIL rmid_strobe got %0b want 0", video_strobe); end
      checks++; if (video_data !== 16'h0) begin errors++; $display("FAIL rmid_data got %h want 0", video_data); end
      checks++; if (dram_addr !== 21'h0) begin errors++; $display("FAIL rmid_addr got %h want 0", dram_addr); end
      checks++; if (dram_video_cycle !== 1'b0 || cpu_slot_free !== 1'b1) begin errors++; $display("FAIL rmid_own got %0b/%0b want 0/1", dram_video_cycle, cpu_slot_free); end
      checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL rmid_overrun got %0b want 0", overrun_err); end
      pulse_frame(21'h00200);
      dram_cycle(1'b1, 1'b1, 1'b0, 16'h0, own, a, stb, d);
      checks++; if (own !== 1'b1) begin errors++; $display("FAIL rmid_first_own got %0b want 1", own); end
      checks++; if (a !== 21'h00200) begin errors++; $display("FAIL rmid_first_addr got %h want 00200", a); end
      dram_cycle(1'b0, 1'b1, 1'b1, 16'h1234, own, a, stb, d);
      checks++; if (stb !== 1'b1 || d !== 16'h1234) begin errors++; $display("FAIL rmid_return got %0b/%h want 1/1234", stb, d); end
      checks++; if (own !== 1'b0) begin errors++; $display("FAIL rmid_close_own got %0b want 0", own); end
   endtask

   initial begin
      rst = 1'b1;
      cend = 1'b0;
      pre_cend = 1'b0;
      video_go = 1'b0;
      frame_start = 1'b0;
      video_base = '0;
      bw_quarter = 1'b0;
      dram_rdata = '0;
      dram_rvalid = 1'b0;
      test_reset();
      test_window(1'b0, 21'h00100, 16);
      test_window(1'b1, 21'h00100, 16);
      test_window(1'b1, 21'h1FFFFF, 9);
      test_cpu_rvalid();
      test_overrun();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
